matrix_seq: RTL and testbench
=============================

# matrix_seq

Command sequencer for the MAX7219-driven 8x8 LED matrix. It owns the 8-row frame buffer, runs the device initialisation sequence after reset and on a periodic re-init timer, and issues row-refresh commands when a new frame is committed. It sits directly upstream of the serial shifter inside `matrix_top`. It hands that shifter 16-bit MAX7219 words (`{4'h0, addr[3:0], data[7:0]}`) over a valid/ready handshake, and the shifter drives `cs`/`dout`.

## Interface
- `INTENSITY`, default 4'h8: low nibble of the intensity register (0x0A) word.
- `SCAN_LIMIT`, default 3'd7: scan-limit register (0x0B) value.
- `REINIT_CYCLES`, default 24'd9_000_000: period in `clk_9m` cycles of the automatic full re-init (1 s); 0 disables re-init.

- `clk_9m`  in  1  sole clock, 9 MHz.
- `pll_rst`  in  1  reset, synchronous, active-high.
- `row_we`  in  1  frame-buffer write strobe.
- `row_addr`  in  3  row index 0..7.
- `row_data`  in  8  row pixels, bit 7 = leftmost column.
- `frame_commit`  in  1  single-cycle request to push the buffer to the display.
- `tx_data`  out  16  MAX7219 word to the shifter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  shifter accepts the word on this edge.
- `busy`  out  1  a sequence (INIT or REFRESH) is in progress.
- `init_done`  out  1  first init sequence has completed.

## Operation
- Frame buffer: 8x8 bits, written whenever `row_we`=1, regardless of state. Cleared to 0 by reset.
- Snapshot: at the start of each sequence's row phase, the buffer is copied to an 8x8 shadow. Row words are taken from the shadow only. A write in the same cycle as the copy lands in the buffer, and the shadow gets the old value.
- FSM states and transitions:
  - INIT: emits 14 words in order: 0x0C00, 0x0F00, 0x0900, {0x0A0,INTENSITY}, {0x0B0,0,SCAN_LIMIT}, then rows 0..7 as {0x0, row+1, shadow[row]}, then 0x0C01. Shadow is copied when entering the row phase (after the 5th word transfers). On completion goes to IDLE.
  - IDLE: `busy`=0. If `reinit_pend`, goes to INIT. Else if `commit_pend`, goes to REFRESH.
  - REFRESH: copies the shadow on entry, then emits 8 words, 0x01xx..0x08xx. On completion goes to IDLE.
- Pending flags:
  - `commit_pend` is set by `frame_commit` in any state and cleared on entry to REFRESH or INIT. A commit during INIT or REFRESH (including the entry cycle) therefore causes exactly one further REFRESH.
  - `reinit_pend` is set when the re-init timer reaches REINIT_CYCLES-1. It has priority over `commit_pend`. Entering INIT clears both flags and resets the timer to 0.
- Timer: 24-bit free-running counter, runs in every state, saturates the pending request; the count wraps to 0 on the request.
- Handshake: a word transfers on an edge with `tx_valid`&&`tx_ready`.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` are held stable.
  - After a transfer, the next word of the same sequence is presented in the following cycle; back-to-back transfers at one word/cycle are legal.
  - `tx_valid` never deasserts mid-sequence except on reset.
- `init_done`: set on transfer of the first INIT's 0x0C01. Held until reset; not cleared by later re-inits.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=16'h0000, `busy`=0, `init_done`=0, flags 0, timer 0, buffer/shadow 0. The FSM enters INIT on the first edge with `pll_rst`=0.
- First word: `tx_valid`=1 with 0x0C00 one cycle after `pll_rst` deasserts; `busy`=1 in the same cycle.
- Commit latency: with `frame_commit` high in cycle N while IDLE, the first row word is valid in cycle N+2.
- `busy` falls in the cycle after the last word's transfer.
- Reset mid-sequence: `tx_valid` goes to 0 on the next edge, the partial sequence is discarded, and the full INIT restarts from 0x0C00.
- Minimum sequence length with `tx_ready` held at 1: INIT 14 cycles, REFRESH 8 cycles.

## Test plan
- Reset release, `tx_ready`=1 -> exactly 14 transfers: 0C00, 0F00, 0900, 0A08, 0B07, 0100..0800, 0C01. `init_done` rises after the 14th; `busy` 1 then 0.
- `tx_ready` held low 20 cycles, then toggled every cycle during INIT -> `tx_data` stable while stalled; 14 distinct words, none dropped or duplicated.
- After init, write rows 0..7 = 0x01, 0x02, 0x04 … 0x80, then pulse commit -> 8 words 0x0101, 0x0202, 0x0304 … 0x0880; first valid 2 cycles after the commit.
- During a REFRESH, write row 3=0xFF and pulse commit -> current refresh sends 0x04 with the old value. Exactly one further refresh follows with 0x04FF.
- REINIT_CYCLES=100, commit pending when the timer expires -> full 14-word INIT runs with current buffer data; no separate REFRESH follows; INIT repeats every ~100 cycles.
- Assert `pll_rst` after 3 INIT transfers -> `tx_valid`=0 next cycle; after release, the sequence restarts at 0x0C00 and `init_done` stays 0 until completion.

Source files
------------

// File: rtl/matrix_seq.sv
// Command sequencer for a MAX7219-driven 8x8 LED matrix: owns the frame buffer,
// runs init / periodic re-init and row-refresh sequences, and feeds 16-bit words to the shifter.
module matrix_seq #(
  parameter logic [3:0]  INTENSITY     = 4'h8,
  parameter logic [2:0]  SCAN_LIMIT    = 3'd7,
  parameter logic [23:0] REINIT_CYCLES = 24'd9_000_000
) (
  input  logic        clk_9m,
  input  logic        pll_rst,
  input  logic        row_we,
  input  logic [2:0]  row_addr,
  input  logic [7:0]  row_data,
  input  logic        frame_commit,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        init_done
);

  typedef enum logic [1:0] { ST_BOOT, ST_IDLE, ST_INIT, ST_REFRESH } state_e;

  localparam logic [3:0] INIT_ROW0 = 4'd5;
  localparam logic [3:0] INIT_LAST = 4'd13;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        init_done_q, init_done_d;
  logic        commit_pend_q, commit_pend_d;
  logic        reinit_pend_q, reinit_pend_d;
  logic [23:0] timer_q, timer_d;

  logic [7:0]  fb_q [8];
  logic [7:0]  shadow_q [8];

  logic        snap;
  logic        xfer;
  logic        enter_init;
  logic        enter_refresh;
  logic [3:0]  nidx;
  logic [2:0]  nrow;

  function automatic logic [15:0] row_word(input logic [2:0] row, input logic [7:0] pix);
    logic [3:0] addr;
    addr = {1'b0, row} + 4'd1;
    return {4'h0, addr, pix};
  endfunction

  function automatic logic [15:0] cfg_word(input logic [3:0] i);
    case (i)
      4'd0:    return 16'h0C00;
      4'd1:    return 16'h0F00;
      4'd2:    return 16'h0900;
      4'd3:    return {8'h0A, 4'h0, INTENSITY};
      4'd4:    return {8'h0B, 5'd0, SCAN_LIMIT};
      default: return 16'h0C01;
    endcase
  endfunction

  // Frame buffer and shadow rows; the shadow copies the buffer's pre-edge value on snap.
  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    always_ff @(posedge clk_9m) begin
      if (pll_rst) begin
        fb_q[gi] <= 8'h00;
      end else if (row_we && (row_addr == 3'(gi))) begin
        fb_q[gi] <= row_data;
      end
    end

    always_ff @(posedge clk_9m) begin
      if (pll_rst) begin
        shadow_q[gi] <= 8'h00;
      end else if (snap) begin
        shadow_q[gi] <= fb_q[gi];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    init_done_d   = init_done_q;
    snap          = 1'b0;
    enter_init    = 1'b0;
    enter_refresh = 1'b0;
    xfer          = tx_valid_q & tx_ready;
    nidx          = idx_q + 4'd1;
    nrow          = 3'(nidx - INIT_ROW0);

    case (state_q)
      ST_BOOT: enter_init = 1'b1;
      ST_IDLE: begin
        if (reinit_pend_q) begin
          enter_init = 1'b1;
        end else if (commit_pend_q) begin
          enter_refresh = 1'b1;
        end
      end
      ST_INIT: if (xfer) begin
        if (idx_q == INIT_LAST) begin
          state_d     = ST_IDLE;
          tx_valid_d  = 1'b0;
          init_done_d = 1'b1;
        end else begin
          idx_d = nidx;
          // Row 0 is sent straight from the buffer on the same edge the shadow is loaded.
          if (nidx == INIT_ROW0) begin
            snap      = 1'b1;
            tx_data_d = row_word(3'd0, fb_q[0]);
          end else if ((nidx > INIT_ROW0) && (nidx < INIT_LAST)) begin
            tx_data_d = row_word(nrow, shadow_q[nrow]);
          end else begin
            tx_data_d = cfg_word(nidx);
          end
        end
      end
      ST_REFRESH: if (xfer) begin
        if (idx_q == 4'd7) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
        end else begin
          idx_d     = nidx;
          tx_data_d = row_word(nidx[2:0], shadow_q[nidx[2:0]]);
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (enter_init) begin
      state_d    = ST_INIT;
      idx_d      = 4'd0;
      tx_valid_d = 1'b1;
      tx_data_d  = cfg_word(4'd0);
    end
    if (enter_refresh) begin
      state_d    = ST_REFRESH;
      idx_d      = 4'd0;
      tx_valid_d = 1'b1;
      snap       = 1'b1;
      tx_data_d  = row_word(3'd0, fb_q[0]);
    end
  end

  // A commit arriving on the same edge as a sequence entry survives the clear.
  always_comb begin
    commit_pend_d = frame_commit | (commit_pend_q & ~(enter_init | enter_refresh));
    reinit_pend_d = reinit_pend_q;
    timer_d       = timer_q + 24'd1;
    if (enter_init) begin
      reinit_pend_d = 1'b0;
      timer_d       = 24'd0;
    end else if ((REINIT_CYCLES != 24'd0) && (timer_q == REINIT_CYCLES - 24'd1)) begin
      reinit_pend_d = 1'b1;
      timer_d       = 24'd0;
    end
  end

  always_ff @(posedge clk_9m) begin
    if (pll_rst) begin
      state_q       <= ST_BOOT;
      idx_q         <= 4'd0;
      tx_data_q     <= 16'h0000;
      tx_valid_q    <= 1'b0;
      init_done_q   <= 1'b0;
      commit_pend_q <= 1'b0;
      reinit_pend_q <= 1'b0;
      timer_q       <= 24'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      init_done_q   <= init_done_d;
      commit_pend_q <= commit_pend_d;
      reinit_pend_q <= reinit_pend_d;
      timer_q       <= timer_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign init_done = init_done_q;
  assign busy      = (state_q == ST_INIT) || (state_q == ST_REFRESH);

endmodule

// File: tb/tb_matrix_seq.sv
// Self-checking bench for matrix_seq: word sequences are predicted from a frame-buffer
// model and compared against the words actually handed over on the valid/ready handshake.
`timescale 1ns/1ps
module tb_matrix_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: default parameters (re-init far beyond the run length)
  logic        rst_a, we_a, commit_a, ready_a;
  logic [2:0]  addr_a;
  logic [7:0]  data_a;
  logic [15:0] txd_a;
  logic        txv_a, busy_a, done_a;

  // DUT B: short re-init period and non-default config nibbles
  logic        rst_b, we_b, commit_b, ready_b;
  logic [2:0]  addr_b;
  logic [7:0]  data_b;
  logic [15:0] txd_b;
  logic        txv_b, busy_b, done_b;

  matrix_seq dut_a (
    .clk_9m(clk), .pll_rst(rst_a), .row_we(we_a), .row_addr(addr_a), .row_data(data_a),
    .frame_commit(commit_a), .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(ready_a),
    .busy(busy_a), .init_done(done_a)
  );

  matrix_seq #(.INTENSITY(4'h3), .SCAN_LIMIT(3'd5), .REINIT_CYCLES(24'd100)) dut_b (
    .clk_9m(clk), .pll_rst(rst_b), .row_we(we_b), .row_addr(addr_b), .row_data(data_b),
    .frame_commit(commit_b), .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(ready_b),
    .busy(busy_b), .init_done(done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  fb_a [8];
  logic [7:0]  fb_b [8];
  logic [15:0] exp_q [$];

  // Transfers are collected mid-cycle: inputs change just after posedge, so valid&&ready
  // seen here is exactly what the next edge will consume.
  logic [15:0] obs_a [$];
  logic [15:0] obs_b [$];
  int          obs_b_cyc [$];
  always @(negedge clk) begin
    if (!rst_a && txv_a && ready_a) obs_a.push_back(txd_a);
    if (!rst_b && txv_b && ready_b) begin
      obs_b.push_back(txd_b);
      obs_b_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_rows(input logic [7:0] rows [8]);
    for (int r = 0; r < 8; r++) exp_q.push_back({4'h0, 4'(r + 1), rows[r]});
  endtask

  task automatic push_init(input logic [3:0] inten, input logic [2:0] sl, input logic [7:0] rows [8]);
    exp_q.push_back(16'h0C00);
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0900);
    exp_q.push_back({8'h0A, 4'h0, inten});
    exp_q.push_back({8'h0B, 5'd0, sl});
    push_rows(rows);
    exp_q.push_back(16'h0C01);
  endtask

  task automatic test_reset();
    int base, n_busy;
    rst_a = 1'b1; ready_a = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (txv_a !== 1'b0 || txd_a !== 16'h0000 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: valid=%b data=%h busy=%b done=%b, expected 0 0000 0 0", txv_a, txd_a, busy_a, done_a);
    end
    for (int r = 0; r < 8; r++) fb_a[r] = 8'h00;
    base = obs_a.size();
    rst_a = 1'b0;
    tick();
    n_checks++;
    if (txv_a !== 1'b1 || txd_a !== 16'h0C00 || busy_a !== 1'b1) begin
      n_errors++;
      $display("FAIL first_word: valid=%b data=%h busy=%b, expected 1 0c00 1", txv_a, txd_a, busy_a);
    end
    n_busy = 0;
    while (busy_a === 1'b1 && n_busy < 100) begin
      n_checks++;
      if (done_a !== 1'b0) begin
        n_errors++;
        $display("FAIL init_done_early: done=%b at busy cycle %0d, expected 0", done_a, n_busy);
      end
      n_busy++;
      tick();
    end
    n_checks++;
    if (n_busy != 14) begin
      n_errors++;
      $display("FAIL init_length: busy for %0d cycles, expected 14", n_busy);
    end
    n_checks++;
    if (done_a !== 1'b1) begin
      n_errors++;
      $display("FAIL init_done: done=%b, expected 1", done_a);
    end
    exp_q.delete();
    push_init(4'h8, 3'd7, fb_a);
    n_checks++;
    if (obs_a.size() - base != exp_q.size()) begin
      n_errors++;
      $display("FAIL reset_init_count: got %0d words, expected %0d", obs_a.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_a.size(); i++) begin
      n_checks++;
      if (obs_a[base + i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL reset_init_word[%0d]: got %h, expected %h", i, obs_a[base + i], exp_q[i]);
      end
    end
    $display("test_reset: %0d words observed", obs_a.size() - base);
  endtask

  task automatic test_stall();
    int base, n;
    logic [15:0] prev_d;
    logic prev_stall;
    logic [2:0] ra;
    logic [7:0] rd;
    rst_a = 1'b1; ready_a = 1'b0;
    tick(); tick();
    for (int r = 0; r < 8; r++) fb_a[r] = 8'h00;
    base = obs_a.size();
    rst_a = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (txv_a !== 1'b1 || txd_a !== 16'h0C00) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h, expected 1 0c00", i, txv_a, txd_a);
      end
      ra = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      we_a = 1'b1; addr_a = ra; data_a = rd;
      fb_a[ra] = rd;
      tick();
    end
    we_a = 1'b0;
    prev_d = 16'h0C00;
    prev_stall = 1'b1;
    n = 0;
    while (busy_a === 1'b1 && n < 200) begin
      if (prev_stall) begin
        n_checks++;
        if (txv_a !== 1'b1 || txd_a !== prev_d) begin
          n_errors++;
          $display("FAIL stall_stable[%0d]: valid=%b data=%h, expected 1 %h", n, txv_a, txd_a, prev_d);
        end
      end
      ready_a = n[0] ? 1'b0 : 1'b1;
      prev_d = txd_a;
      prev_stall = txv_a & ~ready_a;
      n++;
      tick();
    end
    ready_a = 1'b1;
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_timeout: busy=%b after %0d cycles, expected 0", busy_a, n);
    end
    exp_q.delete();
    push_init(4'h8, 3'd7, fb_a);
    n_checks++;
    if (obs_a.size() - base != exp_q.size()) begin
      n_errors++;
      $display("FAIL stall_count: got %0d words, expected %0d", obs_a.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_a.size(); i++) begin
      n_checks++;
      if (obs_a[base + i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL stall_word[%0d]: got %h, expected %h", i, obs_a[base + i], exp_q[i]);
      end
    end
    $display("test_stall: %0d words observed over %0d toggled cycles", obs_a.size() - base, n);
  endtask

  task automatic test_commit();
    int base, n_busy;
    logic [7:0] rd;
    for (int it = 0; it < 4; it++) begin
      base = obs_a.size();
      for (int r = 0; r < 8; r++) begin
        rd = (it == 0) ? 8'(1 << r) : 8'($urandom);
        we_a = 1'b1; addr_a = 3'(r); data_a = rd;
        fb_a[r] = rd;
        tick();
      end
      we_a = 1'b0;
      tick(); tick();
      ready_a = 1'b1;
      commit_a = 1'b1;
      tick();
      commit_a = 1'b0;
      n_checks++;
      if (txv_a !== 1'b0 || busy_a !== 1'b0) begin
        n_errors++;
        $display("FAIL commit_n1[%0d]: valid=%b busy=%b, expected 0 0", it, txv_a, busy_a);
      end
      tick();
      n_checks++;
      if (txv_a !== 1'b1 || txd_a !== {8'h01, fb_a[0]} || busy_a !== 1'b1) begin
        n_errors++;
        $display("FAIL commit_n2[%0d]: valid=%b data=%h busy=%b, expected 1 %h 1", it, txv_a, txd_a, busy_a, {8'h01, fb_a[0]});
      end
      n_busy = 0;
      while (busy_a === 1'b1 && n_busy < 100) begin
        if (it > 0) ready_a = 1'($urandom_range(0, 1));
        n_busy++;
        tick();
      end
      ready_a = 1'b1;
      if (it == 0) begin
        n_checks++;
        if (n_busy != 8) begin
          n_errors++;
          $display("FAIL refresh_length: busy for %0d cycles, expected 8", n_busy);
        end
      end
      exp_q.delete();
      push_rows(fb_a);
      n_checks++;
      if (obs_a.size() - base != exp_q.size()) begin
        n_errors++;
        $display("FAIL commit_count[%0d]: got %0d words, expected %0d", it, obs_a.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < obs_a.size(); i++) begin
        n_checks++;
        if (obs_a[base + i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL commit_word[%0d][%0d]: got %h, expected %h", it, i, obs_a[base + i], exp_q[i]);
        end
      end
      $display("test_commit[%0d]: %0d words, busy %0d cycles", it, obs_a.size() - base, n_busy);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] old_rows [8];
    base = obs_a.size();
    ready_a = 1'b1;
    for (int r = 0; r < 8; r++) begin
      we_a = 1'b1; addr_a = 3'(r); data_a = 8'($urandom);
      fb_a[r] = data_a;
      tick();
    end
    we_a = 1'b0;
    for (int r = 0; r < 8; r++) old_rows[r] = fb_a[r];
    tick();
    commit_a = 1'b1;
    tick();
    commit_a = 1'b0;
    tick();
    n_checks++;
    if (txv_a !== 1'b1) begin
      n_errors++;
      $display("FAIL overlap_start: valid=%b, expected 1", txv_a);
    end
    commit_a = 1'b1;
    tick();
    we_a = 1'b1; addr_a = 3'd3; data_a = 8'hFF;
    fb_a[3] = 8'hFF;
    tick();
    commit_a = 1'b0; we_a = 1'b0;
    repeat (60) tick();
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_errors++;
      $display("FAIL overlap_idle: busy=%b, expected 0", busy_a);
    end
    exp_q.delete();
    push_rows(old_rows);
    push_rows(fb_a);
    n_checks++;
    if (obs_a.size() - base != exp_q.size()) begin
      n_errors++;
      $display("FAIL overlap_count: got %0d words, expected %0d", obs_a.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_a.size(); i++) begin
      n_checks++;
      if (obs_a[base + i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL overlap_word[%0d]: got %h, expected %h", i, obs_a[base + i], exp_q[i]);
      end
    end
    $display("test_back_to_back: %0d words observed", obs_a.size() - base);
  endtask

  task automatic test_reset_mid();
    int base, n;
    rst_a = 1'b1; ready_a = 1'b1;
    tick(); tick();
    for (int r = 0; r < 8; r++) fb_a[r] = 8'h00;
    rst_a = 1'b0;
    tick(); tick(); tick(); tick();
    rst_a = 1'b1;
    tick();
    n_checks++;
    if (txv_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_drop: valid=%b busy=%b done=%b, expected 0 0 0", txv_a, busy_a, done_a);
    end
    tick();
    base = obs_a.size();
    rst_a = 1'b0;
    tick();
    n_checks++;
    if (txv_a !== 1'b1 || txd_a !== 16'h0C00) begin
      n_errors++;
      $display("FAIL midreset_restart: valid=%b data=%h, expected 1 0c00", txv_a, txd_a);
    end
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      n_checks++;
      if (done_a !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_done_early: done=%b at cycle %0d, expected 0", done_a, n);
      end
      n++;
      tick();
    end
    n_checks++;
    if (done_a !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_done: done=%b, expected 1", done_a);
    end
    exp_q.delete();
    push_init(4'h8, 3'd7, fb_a);
    n_checks++;
    if (obs_a.size() - base != exp_q.size()) begin
      n_errors++;
      $display("FAIL midreset_count: got %0d words, expected %0d", obs_a.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_a.size(); i++) begin
      n_checks++;
      if (obs_a[base + i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL midreset_word[%0d]: got %h, expected %h", i, obs_a[base + i], exp_q[i]);
      end
    end
    $display("test_reset_mid: %0d words after restart", obs_a.size() - base);
  endtask

  task automatic test_reinit();
    int base, t0;
    logic [7:0] zr [8];
    for (int r = 0; r < 8; r++) begin
      zr[r] = 8'h00;
      fb_b[r] = 8'h00;
    end
    rst_b = 1'b1; ready_b = 1'b1;
    tick(); tick();
    base = obs_b.size();
    rst_b = 1'b0;
    tick();
    t0 = cyc;
    n_checks++;
    if (txv_b !== 1'b1 || txd_b !== 16'h0C00) begin
      n_errors++;
      $display("FAIL reinit_first: valid=%b data=%h, expected 1 0c00", txv_b, txd_b);
    end
    while (cyc < t0 + 20) tick();
    for (int r = 0; r < 8; r++) begin
      we_b = 1'b1; addr_b = 3'(r); data_b = 8'($urandom);
      fb_b[r] = data_b;
      tick();
    end
    we_b = 1'b0;
    // Commit lands on the same edge the re-init request is raised.
    while (cyc < t0 + 99) tick();
    commit_b = 1'b1;
    tick();
    commit_b = 1'b0;
    while (cyc < t0 + 320) tick();
    exp_q.delete();
    push_init(4'h3, 3'd5, zr);
    for (int k = 0; k < 3; k++) push_init(4'h3, 3'd5, fb_b);
    n_checks++;
    if (obs_b.size() - base != exp_q.size()) begin
      n_errors++;
      $display("FAIL reinit_count: got %0d words, expected %0d", obs_b.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_b.size(); i++) begin
      n_checks++;
      if (obs_b[base + i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL reinit_word[%0d]: got %h, expected %h", i, obs_b[base + i], exp_q[i]);
      end
    end
    for (int k = 0; k < 4 && base + 14 * k < obs_b.size(); k++) begin
      n_checks++;
      if (obs_b_cyc[base + 14 * k] != t0 + 101 * k) begin
        n_errors++;
        $display("FAIL reinit_period[%0d]: init started at cycle %0d, expected %0d", k, obs_b_cyc[base + 14 * k] - t0, 101 * k);
      end
    end
    n_checks++;
    if (done_b !== 1'b1) begin
      n_errors++;
      $display("FAIL reinit_done: done=%b, expected 1", done_b);
    end
    $display("test_reinit: %0d words observed", obs_b.size() - base);
  endtask

  initial begin
    rst_a = 1'b1; we_a = 1'b0; addr_a = 3'd0; data_a = 8'h00; commit_a = 1'b0; ready_a = 1'b0;
    rst_b = 1'b1; we_b = 1'b0; addr_b = 3'd0; data_b = 8'h00; commit_b = 1'b0; ready_b = 1'b0;
    test_reset();
    test_stall();
    test_commit();
    test_back_to_back();
    test_reset_mid();
    test_reinit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
